// File: rtl/cpu_bus_pkg.sv
// Shared types for the 6809-style E/Q clock generator and bus arbiter:
// arbiter state enum, phase encoding constants and the phase-to-clock map.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_HREQ  = 2'd1,
    ARB_GRANT = 2'd2,
    ARB_HREL  = 2'd3
  } arb_state_t;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  typedef struct packed {
    logic e;
    logic q;
  } eq_t;

  function automatic eq_t phase_to_eq(input logic [1:0] ph);
    eq_t r;
    r = '0;
    case (ph)
      PH0: begin r.e = 1'b0; r.q = 1'b0; end
      PH1: begin r.e = 1'b0; r.q = 1'b1; end
      PH2: begin r.e = 1'b1; r.q = 1'b1; end
      default: begin r.e = 1'b1; r.q = 1'b0; end
    endcase
    return r;
  endfunction

  // The CPU keeps its buffers on the bus until the grant is actually given.
  function automatic logic cpu_owns_bus(input arb_state_t st);
    return (st == ARB_IDLE) || (st == ARB_HREQ);
  endfunction

endpackage

// File: rtl/cpu_bus_ctl_if.sv
// CPU-side status, external requests, generated clocks, grants and strobes
// bundled for the bus controller.
interface cpu_bus_ctl_if #(
  parameter int NMASTERS = 2
);
  logic                rnw;
  logic                ba;
  logic                bs;
  logic [NMASTERS-1:0] req;
  logic                e;
  logic                q;
  logic                efall;
  logic                halt_n;
  logic [NMASTERS-1:0] gnt;
  logic                busoe_n;
  logic                rde_n;
  logic                rdqe_n;
  logic                wtqe_n;

  modport master (
    input  rnw, ba, bs, req,
    output e, q, efall, halt_n, gnt, busoe_n, rde_n, rdqe_n, wtqe_n
  );

  modport slave (
    output rnw, ba, bs, req,
    input  e, q, efall, halt_n, gnt, busoe_n, rde_n, rdqe_n, wtqe_n
  );
endinterface

// File: rtl/cpu_eq_gen.sv
// E/Q quadrature clock generator: DIV-clock prescaler, 2-bit phase, registered
// E/Q and a one-clock EFALL enable on the last clock before E falls.
module cpu_eq_gen
  import cpu_bus_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       e,
  output logic       q,
  output logic       efall,
  output logic [1:0] phase_next
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  generate
    if (DIV < 1 || DIV > 16) begin : g_div_check
      $error("cpu_eq_gen: DIV=%0d outside legal range 1..16", DIV);
    end
  endgenerate

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    phase_reg;
  logic          e_reg, q_reg, efall_reg;
  logic          efall_next;
  eq_t           eq_next;

  always_comb begin
    cnt_next   = cnt_reg + CW'(1);
    phase_next = phase_reg;
    if (cnt_reg == CNT_LAST) begin
      cnt_next   = '0;
      phase_next = phase_reg + 2'd1;
    end
  end

  // Clocks are decoded from next-state so E/Q leave a flop, never a gate.
  assign eq_next    = phase_to_eq(phase_next);
  assign efall_next = (phase_next == PH3) && (cnt_next == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      phase_reg <= PH0;
      e_reg     <= 1'b0;
      q_reg     <= 1'b0;
      efall_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
      e_reg     <= eq_next.e;
      q_reg     <= eq_next.q;
      efall_reg <= efall_next;
    end
  end

  assign e     = e_reg;
  assign q     = q_reg;
  assign efall = efall_reg;

endmodule

// File: rtl/cpu_bus_ctl.sv
// CPU bus controller: E/Q generation, HALT-based bus arbitration for external
// masters, and registered read/write strobes gated by bus ownership.
module cpu_bus_ctl
  import cpu_bus_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int NMASTERS = 2
) (
  input  logic           clk,
  input  logic           rst,
  cpu_bus_ctl_if.master  bus
);

  localparam int WW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

  arb_state_t    state_reg, state_next;
  logic [WW-1:0] winner_reg, winner_next;
  logic [WW-1:0] lowest_req;
  logic          winner_req;
  logic [1:0]    phase_next;
  logic          efall;
  logic          halt_n, busoe_n, grant_on;
  logic          rde_n_reg, rdqe_n_reg, wtqe_n_reg;
  logic          cpu_next;
  eq_t           eq_next;

  cpu_eq_gen #(
    .DIV (DIV)
  ) u_eq_gen (
    .clk        (clk),
    .rst        (rst),
    .e          (bus.e),
    .q          (bus.q),
    .efall      (efall),
    .phase_next (phase_next)
  );

  assign bus.efall = efall;

  generate
    if (NMASTERS < 1 || NMASTERS > 4) begin : g_nm_check
      $error("cpu_bus_ctl: NMASTERS=%0d outside legal range 1..4", NMASTERS);
    end
    if (NMASTERS == 1) begin : g_single
      assign lowest_req = '0;
      assign winner_req = bus.req[0];
    end else begin : g_multi
      always_comb begin
        lowest_req = '0;
        for (int i = NMASTERS - 1; i >= 0; i--) begin
          if (bus.req[i]) lowest_req = WW'(i);
        end
      end
      assign winner_req = bus.req[winner_reg];
    end
    for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_gnt
      assign bus.gnt[gi] = grant_on && (winner_reg == WW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ARB_IDLE;
      winner_reg <= '0;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
    end
  end

  // Every decision is taken at a CPU cycle boundary so HALT/BA stay coherent.
  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    if (efall) begin
      case (state_reg)
        ARB_IDLE: begin
          if (|bus.req) begin
            winner_next = lowest_req;
            state_next  = ARB_HREQ;
          end
        end
        ARB_HREQ: begin
          if (!winner_req)              state_next = ARB_HREL;
          else if (bus.ba && bus.bs)    state_next = ARB_GRANT;
        end
        ARB_GRANT: begin
          if (!winner_req) state_next = ARB_HREL;
        end
        ARB_HREL: begin
          if (!bus.ba) state_next = ARB_IDLE;
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    halt_n   = 1'b1;
    busoe_n  = 1'b0;
    grant_on = 1'b0;
    case (state_reg)
      ARB_HREQ:  halt_n = 1'b0;
      ARB_GRANT: begin
        halt_n   = 1'b0;
        busoe_n  = 1'b1;
        grant_on = 1'b1;
      end
      ARB_HREL:  busoe_n = 1'b1;
      default: ;
    endcase
  end

  assign bus.halt_n  = halt_n;
  assign bus.busoe_n = busoe_n;

  // Strobes use next phase and next ownership so they line up with E/Q.
  assign eq_next  = phase_to_eq(phase_next);
  assign cpu_next = cpu_owns_bus(state_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rde_n_reg  <= 1'b1;
      rdqe_n_reg <= 1'b1;
      wtqe_n_reg <= 1'b1;
    end else begin
      rde_n_reg  <= ~(cpu_next &  bus.rnw & eq_next.e);
      rdqe_n_reg <= ~(cpu_next &  bus.rnw & (eq_next.e | eq_next.q));
      wtqe_n_reg <= ~(cpu_next & ~bus.rnw & eq_next.e & eq_next.q);
    end
  end

  assign bus.rde_n  = rde_n_reg;
  assign bus.rdqe_n = rdqe_n_reg;
  assign bus.wtqe_n = wtqe_n_reg;

endmodule

// File: tb/tb_cpu_bus_ctl.sv
// Bench for cpu_bus_ctl: directed arbitration scenarios plus randomized
// requests, checked every clock against a cycle-count / flag-based model.
module tb_cpu_bus_ctl;

  localparam int         DIV     = 4;
  localparam int         NM      = 2;
  localparam int         CYC     = 4 * DIV;
  localparam logic [9:0] RST_VEC = 10'b000_1_0_00_111;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cpu_bus_ctl_if #(.NMASTERS(NM)) bus ();

  cpu_bus_ctl #(
    .DIV      (DIV),
    .NMASTERS (NM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: time since reset and three ownership flags.
  int t;
  bit m_halting, m_granted, m_ext;
  int m_owner;
  int hcnt, rcnt, rel_dly, first_q;
  int n_abort;
  int n_grant [NM];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.e, bus.q, bus.efall, bus.halt_n, bus.busoe_n, bus.gnt,
            bus.rde_n, bus.rdqe_n, bus.wtqe_n};
  endfunction

  task automatic model_reset();
    t         = 0;
    m_halting = 0;
    m_granted = 0;
    m_ext     = 0;
    m_owner   = 0;
    hcnt      = 0;
    rcnt      = 0;
    rel_dly   = 1;
    first_q   = -1;
  endtask

  // Arbitration as seen at one CPU cycle boundary.
  task automatic arb_model();
    if (!m_halting && !m_ext) begin
      if (bus.req != '0) begin
        for (int i = 0; i < NM; i++) begin
          if (bus.req[i]) begin
            m_owner = i;
            break;
          end
        end
        m_halting = 1;
      end
    end else if (m_halting && !m_granted) begin
      if (!bus.req[m_owner]) begin
        m_halting = 0;
        m_ext     = 1;
        rel_dly   = $urandom_range(1, 3);
        n_abort++;
        $display("[TB] request of master %0d withdrawn before grant at %0t", m_owner, $time);
      end else if (bus.ba && bus.bs) begin
        m_granted = 1;
        m_ext     = 1;
        n_grant[m_owner]++;
        $display("[TB] bus granted to master %0d at %0t", m_owner, $time);
      end
    end else if (m_granted) begin
      if (!bus.req[m_owner]) begin
        m_granted = 0;
        m_halting = 0;
        rel_dly   = $urandom_range(1, 3);
        $display("[TB] master %0d released bus at %0t", m_owner, $time);
      end
    end else if (!bus.ba) begin
      m_ext = 0;
    end
    if (m_halting) begin
      hcnt++;
      rcnt = 0;
    end else begin
      hcnt = 0;
      rcnt++;
    end
  endtask

  task automatic step();
    int         ph;
    bit         ee, qq, ef, rnw_s, cpu_on;
    logic [NM-1:0] g;
    rnw_s = bus.rnw;
    @(posedge clk);
    if ((t % CYC) == CYC - 1) arb_model();
    t++;
    ph     = (t / DIV) % 4;
    ee     = (ph == 2) || (ph == 3);
    qq     = (ph == 1) || (ph == 2);
    ef     = (t % CYC) == CYC - 1;
    cpu_on = !m_ext;
    g      = m_granted ? NM'(1 << m_owner) : '0;
    @(negedge clk);
    check("eq_clocks", int'({bus.e, bus.q, bus.efall}), int'({ee, qq, ef}));
    check("arbiter", int'({bus.halt_n, bus.busoe_n, bus.gnt}), int'({~m_halting, m_ext, g}));
    check("strobes", int'({bus.rde_n, bus.rdqe_n, bus.wtqe_n}),
          int'({~(cpu_on & rnw_s & ee), ~(cpu_on & rnw_s & (ee | qq)),
                ~(cpu_on & ~rnw_s & ee & qq)}));
    if (bus.q && first_q < 0) first_q = t;
    // CPU model: BA/BS follow HALT after two cycles, drop 1..3 cycles after release.
    if (m_halting) bus.ba = (hcnt >= 2);
    else           bus.ba = bus.ba && (rcnt < rel_dly);
    bus.bs = bus.ba && ($urandom_range(0, 7) != 0);
  endtask

  task automatic wait_gnt(input logic [NM-1:0] want, input int budget, input string tag);
    int n = 0;
    while (bus.gnt !== want && n < budget) begin
      step();
      n++;
    end
    check(tag, int'(bus.gnt), int'(want));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((bus.halt_n !== 1'b1 || bus.busoe_n !== 1'b0) && n < budget) begin
      step();
      n++;
    end
    check(tag, int'({bus.halt_n, bus.busoe_n}), 2);
  endtask

  task automatic random_inputs();
    if ($urandom_range(0, 7) == 0) bus.rnw = ~bus.rnw;
    for (int i = 0; i < NM; i++) begin
      if (!bus.req[i]) begin
        if ($urandom_range(0, 63) == 0) bus.req[i] = 1'b1;
      end else if (m_granted && m_owner == i) begin
        if ($urandom_range(0, 3 * CYC) == 0) bus.req[i] = 1'b0;
      end else if ($urandom_range(0, 6 * CYC) == 0) begin
        bus.req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    bit saw_gnt;
    int n;
    bus.rnw = 1'b1;
    bus.ba  = 1'b0;
    bus.bs  = 1'b0;
    bus.req = '0;
    n_abort = 0;
    for (int i = 0; i < NM; i++) n_grant[i] = 0;
    model_reset();

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", int'(outs()), int'(RST_VEC));
    rst = 1'b0;
    model_reset();

    // Idle bus: read cycles, then write cycles.
    repeat (2 * CYC) step();
    bus.rnw = 1'b0;
    repeat (2 * CYC) step();
    check("q_first_rise", first_q, DIV);

    // Two simultaneous requests: master 0 first, master 1 after hand-back.
    bus.rnw = 1'b1;
    bus.req = 2'b11;
    wait_gnt(2'b01, 10 * CYC, "gnt_m0_first");
    repeat (2 * CYC) step();
    bus.req[0] = 1'b0;
    wait_gnt(2'b10, 20 * CYC, "gnt_m1_after");
    repeat (CYC) step();
    bus.req[1] = 1'b0;
    wait_idle(20 * CYC, "release_m1");

    // Request withdrawn while HALT is pending.
    bus.req = 2'b01;
    n = 0;
    while (bus.halt_n !== 1'b0 && n < 10 * CYC) begin
      step();
      n++;
    end
    check("halt_asserted", int'(bus.halt_n), 0);
    bus.req = '0;
    saw_gnt = 0;
    repeat (6 * CYC) begin
      step();
      if (bus.gnt != '0) saw_gnt = 1;
    end
    check("abort_no_gnt", int'(saw_gnt), 0);
    check("abort_halt_n", int'({bus.halt_n, bus.busoe_n}), 2);

    repeat (5000) begin
      random_inputs();
      step();
    end

    // Asynchronous reset in the middle of a master 1 grant.
    bus.req = '0;
    wait_idle(20 * CYC, "idle_before_reset");
    bus.req = 2'b10;
    wait_gnt(2'b10, 20 * CYC, "gnt_m1_pre_reset");
    #2 rst = 1'b1;
    #1 check("async_reset", int'(outs()), int'(RST_VEC));
    @(negedge clk);
    check("reset_hold", int'(outs()), int'(RST_VEC));
    bus.req = '0;
    bus.ba  = 1'b0;
    bus.bs  = 1'b0;
    rst     = 1'b0;
    model_reset();
    repeat (3 * CYC) step();
    check("q_rise_after_reset", first_q, DIV);

    $display("[TB] grants m0=%0d m1=%0d withdrawn=%0d", n_grant[0], n_grant[1], n_abort);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctl.md
CPU_BUS_CTL -- requirements
Module: cpu_bus_ctl

Interface
REQ-001 Parameter DIV, default 4, system clocks per E/Q quarter-phase (legal 1..16).
REQ-002 Parameter NMASTERS, default 2, number of external bus requesters (legal 1..4).
REQ-003 CLKSYS  in  1  system clock; all state on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 RnW  in  1  CPU read/write (1 = read).
REQ-006 BA  in  1  CPU bus-available status.
REQ-007 BS  in  1  CPU bus-status.
REQ-008 REQ  in  NMASTERS  per-master bus request, level, held until done.
REQ-009 E  out  1  CPU E clock.
REQ-010 Q  out  1  CPU Q clock.
REQ-011 EFALL  out  1  one-CLKSYS pulse on last clock before E falls (CPU cycle-end enable).
REQ-012 HALTn  out  1  CPU halt request, active-low.
REQ-013 GNT  out  NMASTERS  one-hot bus grant.
REQ-014 BUSOEn  out  1  CPU address/data/strobe buffer enable, low = CPU drives bus.
REQ-015 RDEn  out  1  read strobe, low = RnW & E & CPU owns bus.
REQ-016 RDQEn  out  1  early read strobe, low = RnW & (Q | E) & CPU owns bus.
REQ-017 WTQEn  out  1  write strobe, low = ~RnW & Q & E & CPU owns bus.

Function
REQ-018 Phase sequencer: 2-bit phase P, DIV-clock prescaler; P advances 0->1->2->3->0 each DIV clocks; full CPU cycle = 4*DIV clocks.
REQ-019 Clock encoding: P0 E=0 Q=0; P1 E=0 Q=1; P2 E=1 Q=1; P3 E=1 Q=0; E and Q registered, glitch-free.
REQ-020 EFALL = 1 exactly in last prescaler clock of P3.
REQ-021 Strobes registered from next-state P and RnW; all three strobes forced high whenever BUSOEn = 1.
REQ-022 Arbiter states: IDLE, HREQ, GRANT, HREL.
REQ-023 IDLE: HALTn=1, GNT=0, BUSOEn=0; on EFALL with any REQ set, latch winner (lowest index set) and enter HREQ.
REQ-024 HREQ: HALTn=0; on EFALL with BA=1 and BS=1 sampled, enter GRANT; if winner's REQ drops first, enter HREL.
REQ-025 GRANT: GNT[winner]=1, BUSOEn=1, HALTn=0; no preemption by other requests; on EFALL with winner REQ=0, enter HREL.
REQ-026 HREL: GNT=0, HALTn=1, BUSOEn=1; on EFALL with BA=0 sampled, enter IDLE (BUSOEn=0 same cycle).
REQ-027 Outputs GNT, HALTn, BUSOEn change only on EFALL boundaries; GNT deasserts one cycle before BUSOEn returns low.
REQ-028 Simultaneous requests: lowest index wins; losers remain pending and are served via IDLE next arbitration.
REQ-029 REQ sampled only at EFALL; requests narrower than one CPU cycle may be missed (by design).
REQ-030 NMASTERS=1: arbiter degenerates, winner index constant 0.

Reset
REQ-031 RESET asserted (any time, incl. mid-grant): P=0, prescaler=0, E=0, Q=0, EFALL=0, state IDLE, HALTn=1, GNT=0, BUSOEn=0, RDEn=RDQEn=WTQEn=1.
REQ-032 After RESET release, first Q rise occurs DIV clocks later.

Structure
REQ-033 Shared package cpu_bus_pkg holds arbiter state enum and phase encoding constants.
REQ-034 Sub-module cpu_eq_gen implements prescaler, phase, E, Q, EFALL; arbiter and strobes live in cpu_bus_ctl.
REQ-035 Parameter checks (DIV, NMASTERS range) as elaboration-time assertions.

Verification
REQ-036 DIV=4, no REQ -> E period 16 clocks, Q rises 4 clocks before E, EFALL once per 16 clocks, BUSOEn=0 throughout.
REQ-037 RnW=1 -> RDQEn low 12 of 16 clocks, RDEn low 8, WTQEn high; RnW=0 -> WTQEn low 4 clocks (P2 only).
REQ-038 REQ=2'b01, CPU model raises BA=BS=1 two cycles after HALTn low -> GNT=01 and BUSOEn=1 at following EFALL, strobes high.
REQ-039 REQ=2'b11 together -> GNT=01 first; drop REQ[0] -> HREL, BA=0 -> IDLE, then GNT=10 after next handshake.
REQ-040 REQ[0] drops during HREQ -> HALTn returns 1 without GNT ever asserting.
REQ-041 RESET pulsed while GNT=10 -> all outputs at REQ-031 values same edge, asynchronously.
